// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply step sequencer. The divider's
// consumers and the MAC datapath use the same state encoding and defaults.
package mm_pkg;

    // Default square matrix dimension and address width.
    localparam int MM_N_DEFAULT      = 3;
    localparam int MM_ADDR_W_DEFAULT = 8;

    // Width of the row/col/k index counters; holds any dimension up to 15.
    localparam int MM_IDX_W = 4;

    // Sequencer states. The encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } mm_state_e;

    // Row-major linear address major*dim+minor, computed at full 32-bit
    // width; callers truncate to their own address width.
    function automatic int unsigned mm_lin_addr(input int unsigned major,
                                                input int unsigned minor,
                                                input int unsigned dim);
        return major * dim + minor;
    endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Two-flop synchroniser for the divided step clock level followed by a
// rising-edge detector. The level is sampled as data on clock_in; pulse_out
// is high for exactly one clock_in cycle per 0->1 transition of level_in.
// Both flops reset to 1 so a level that is already high when reset is
// released cannot masquerade as a rising edge.
module step_edge_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);

    logic sync1_q;
    logic sync2_q;

    // Synchroniser chain; preset to 1 on reset.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= level_in;
            sync2_q <= sync1_q;
        end
    end

    // Rising edge: newest sample high, previous sample low.
    assign pulse_out = sync1_q & ~sync2_q;

endmodule

// File: rtl/mm_step_sequencer.sv
// Address/strobe sequencer for C = A * B on N x N matrices. Each step pulse
// advances the sequence by one action: clear the accumulator, one
// multiply-accumulate per k, then write the finished C element.
//
// Strobe semantics: acc_clear, acc_en, c_we and done are registered,
// one clock_in cycle wide, mutually exclusive, and at most one fires per step
// pulse. The consumer must act in the cycle a strobe is high; there is no
// back-pressure. a_addr/b_addr are valid in the acc_en cycle and c_addr in
// the c_we cycle; each address holds its value until its next strobe.
module mm_step_sequencer
    import mm_pkg::*;
#(
    parameter int N      = MM_N_DEFAULT,
    parameter int ADDR_W = MM_ADDR_W_DEFAULT
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              step_clk,
    input  logic              start,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              c_we,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    // Elaboration-time legality checks on the parameters.
    generate
        if (N < 2 || N > 15) begin : g_bad_n
            $error("mm_step_sequencer: N must be in 2..15");
        end
        if (ADDR_W < 1 || (ADDR_W < 31 && (N * N > (1 << ADDR_W)))) begin : g_bad_addr_w
            $error("mm_step_sequencer: N*N does not fit in ADDR_W address bits");
        end
    endgenerate

    localparam logic [MM_IDX_W-1:0] LAST_IDX = MM_IDX_W'(N - 1);

    mm_state_e           state_q;
    mm_state_e           state_d;
    logic [MM_IDX_W-1:0] row_q;
    logic [MM_IDX_W-1:0] col_q;
    logic [MM_IDX_W-1:0] k_q;
    logic                step_pulse;
    logic                last_elem;

    logic                acc_clear_d;
    logic                acc_en_d;
    logic                c_we_d;
    logic                done_d;
    logic [ADDR_W-1:0]   a_addr_d;
    logic [ADDR_W-1:0]   b_addr_d;
    logic [ADDR_W-1:0]   c_addr_d;

    step_edge_detect u_step_edge (
        .clock_in  (clock_in),
        .reset     (reset),
        .level_in  (step_clk),
        .pulse_out (step_pulse)
    );

    // The C element currently addressed is the bottom-right one.
    assign last_elem = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    // State register.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every state except IDLE and FIN waits for a step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (step_pulse) begin
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (step_pulse && (k_q == LAST_IDX)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (step_pulse) begin
                    state_d = last_elem ? ST_FIN : ST_CLEAR;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: next values of the registered strobes and addresses.
    always_comb begin
        acc_clear_d = (state_q == ST_CLEAR) && step_pulse;
        acc_en_d    = (state_q == ST_MAC)   && step_pulse;
        c_we_d      = (state_q == ST_WRITE) && step_pulse;
        done_d      = (state_q == ST_FIN);
        a_addr_d    = ADDR_W'(mm_lin_addr(32'(row_q), 32'(k_q),   N));
        b_addr_d    = ADDR_W'(mm_lin_addr(32'(k_q),   32'(col_q), N));
        c_addr_d    = ADDR_W'(mm_lin_addr(32'(row_q), 32'(col_q), N));
    end

    // Index counters: k walks the dot product, col/row walk C in row-major order.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
            k_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        row_q <= '0;
                        col_q <= '0;
                        k_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (step_pulse) begin
                        k_q <= '0;
                    end
                end
                ST_MAC: begin
                    if (step_pulse) begin
                        k_q <= (k_q == LAST_IDX) ? '0 : k_q + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (step_pulse && !last_elem) begin
                        if (col_q == LAST_IDX) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered strobes; each address only moves when its strobe fires.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            acc_clear <= 1'b0;
            acc_en    <= 1'b0;
            c_we      <= 1'b0;
            done      <= 1'b0;
            a_addr    <= '0;
            b_addr    <= '0;
            c_addr    <= '0;
        end else begin
            acc_clear <= acc_clear_d;
            acc_en    <= acc_en_d;
            c_we      <= c_we_d;
            done      <= done_d;
            if (acc_en_d) begin
                a_addr <= a_addr_d;
                b_addr <= b_addr_d;
            end
            if (c_we_d) begin
                c_addr <= c_addr_d;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mm_step_sequencer.sv
// Directed bench for mm_step_sequencer: an N=2 instance and an N=3 instance
// share clock, reset and step clock; each has its own start and its own
// queue of expected strobe events.
`timescale 1ns/1ps
module tb_mm_step_sequencer;
    import mm_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock_in = 1'b0;
    logic reset;
    logic step_clk;
    logic start2;
    logic start3;

    always #5 clock_in = ~clock_in;

    logic [7:0] a_addr2, b_addr2, c_addr2, a_addr3, b_addr3, c_addr3;
    logic       acc_clear2, acc_en2, c_we2, busy2, done2;
    logic       acc_clear3, acc_en3, c_we3, busy3, done3;
    logic [2:0] state_dbg2, state_dbg3;

    mm_step_sequencer #(.N(2), .ADDR_W(8)) dut2 (
        .clock_in(clock_in), .reset(reset), .step_clk(step_clk), .start(start2),
        .a_addr(a_addr2), .b_addr(b_addr2), .c_addr(c_addr2),
        .acc_clear(acc_clear2), .acc_en(acc_en2), .c_we(c_we2),
        .busy(busy2), .done(done2), .state_dbg(state_dbg2)
    );

    mm_step_sequencer #(.N(3), .ADDR_W(8)) dut3 (
        .clock_in(clock_in), .reset(reset), .step_clk(step_clk), .start(start3),
        .a_addr(a_addr3), .b_addr(b_addr3), .c_addr(c_addr3),
        .acc_clear(acc_clear3), .acc_en(acc_en3), .c_we(c_we3),
        .busy(busy3), .done(done3), .state_dbg(state_dbg3)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Event word: kind 1=clear, 2=mac(a,b), 3=write(c).
    function automatic logic [31:0] mk_ev(input logic [1:0] kind, input logic [7:0] x, input logic [7:0] y);
        return {6'd0, kind, 8'd0, x, y};
    endfunction

    localparam logic [31:0] EV_NONE = 32'hFFFF_FFFF;

    // Hand-computed N=2 strobe order.
    logic [31:0] seq2_tab [16] = '{
        32'h0100_0000, 32'h0200_0000, 32'h0200_0102, 32'h0300_0000,
        32'h0100_0000, 32'h0200_0001, 32'h0200_0103, 32'h0300_0100,
        32'h0100_0000, 32'h0200_0200, 32'h0200_0302, 32'h0300_0200,
        32'h0100_0000, 32'h0200_0201, 32'h0200_0303, 32'h0300_0300
    };

    // ---------------- scoreboard ----------------
    logic [31:0] exp2_q[$];
    logic [31:0] exp3_q[$];

    task automatic push_seq2();
        for (int i = 0; i < 16; i++) exp2_q.push_back(seq2_tab[i]);
    endtask

    task automatic push_seq3();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp3_q.push_back(mk_ev(2'd1, 8'd0, 8'd0));
                for (int k = 0; k < 3; k++) begin
                    exp3_q.push_back(mk_ev(2'd2, 8'(r * 3 + k), 8'(k * 3 + c)));
                end
                exp3_q.push_back(mk_ev(2'd3, 8'(r * 3 + c), 8'd0));
            end
        end
    endtask

    // ---------------- step clock driver ----------------
    logic step_run   = 1'b1;
    logic step_force = 1'b0;
    int   gen_cnt    = 0;
    int   rises      = 0;

    initial begin
        step_clk = 1'b0;
        forever begin
            @(negedge clock_in);
            if (step_run) begin
                gen_cnt++;
                if (gen_cnt == 4) begin
                    gen_cnt  = 0;
                    step_clk = ~step_clk;
                    if (step_clk) rises++;
                end
            end else if (step_force != step_clk) begin
                step_clk = step_force;
                if (step_clk) rises++;
            end
        end
    end

    // ---------------- monitors ----------------
    int clr_cnt2 = 0, en_cnt2 = 0, we_cnt2 = 0, done_cnt2 = 0;
    int clr_cnt3 = 0, en_cnt3 = 0, we_cnt3 = 0, done_cnt3 = 0;
    logic [31:0] obs2, obs3;

    initial begin
        forever begin
            @(negedge clock_in);
            if (acc_clear2 | acc_en2 | c_we2 | done2) begin
                check("excl2", 32'(acc_clear2) + 32'(acc_en2) + 32'(c_we2) + 32'(done2), 32'd1);
            end
            if (acc_clear2 | acc_en2 | c_we2) begin
                obs2 = acc_clear2 ? mk_ev(2'd1, 8'd0, 8'd0) :
                       acc_en2    ? mk_ev(2'd2, a_addr2, b_addr2) : mk_ev(2'd3, c_addr2, 8'd0);
                check("strobe2", obs2, (exp2_q.size() == 0) ? EV_NONE : exp2_q.pop_front());
                if (acc_clear2) clr_cnt2++;
                if (acc_en2) en_cnt2++;
                if (c_we2) we_cnt2++;
            end
            if (done2) done_cnt2++;
        end
    end

    initial begin
        forever begin
            @(negedge clock_in);
            if (acc_clear3 | acc_en3 | c_we3 | done3) begin
                check("excl3", 32'(acc_clear3) + 32'(acc_en3) + 32'(c_we3) + 32'(done3), 32'd1);
            end
            if (acc_clear3 | acc_en3 | c_we3) begin
                obs3 = acc_clear3 ? mk_ev(2'd1, 8'd0, 8'd0) :
                       acc_en3    ? mk_ev(2'd2, a_addr3, b_addr3) : mk_ev(2'd3, c_addr3, 8'd0);
                check("strobe3", obs3, (exp3_q.size() == 0) ? EV_NONE : exp3_q.pop_front());
                if (acc_clear3) clr_cnt3++;
                if (acc_en3) en_cnt3++;
                if (c_we3) we_cnt3++;
            end
            if (done3) done_cnt3++;
        end
    end

    // ---------------- driver tasks ----------------
    // Wait until step_clk has just fallen, so the next rise is well clear.
    task automatic align_fall();
        for (int i = 0; i < 40; i++) begin
            @(posedge clock_in);
            if (!step_clk && gen_cnt == 0) return;
        end
        check("align_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start(input int which);
        @(negedge clock_in);
        if (which == 2) start2 = 1'b1; else start3 = 1'b1;
        @(negedge clock_in);
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock_in);
            if ((which == 2) ? done2 : done3) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    int r0, c0, e0, w0, d0;
    initial begin
        reset  = 1'b1;
        start2 = 1'b0;
        start3 = 1'b0;
        repeat (4) @(negedge clock_in);
        check("rst_busy3", busy3, 0);
        check("rst_state3", state_dbg3, 32'(ST_IDLE));
        check("rst_strobes3", {acc_clear3, acc_en3, c_we3, done3}, 0);
        check("rst_addr3", {a_addr3, b_addr3, c_addr3}, 0);
        check("rst_busy2", busy2, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock_in);

        // Scenario 1: N=2 full run against the hand-written strobe table.
        push_seq2();
        align_fall();
        pulse_start(2);
        r0 = rises;
        wait_done(2, 400);
        @(posedge clock_in);
        check("s1_pulses", rises - r0, 16);
        check("s1_done_cnt", done_cnt2, 1);
        check("s1_we_cnt", we_cnt2, 4);
        check("s1_q_empty", exp2_q.size(), 0);

        // Scenarios 5 + 2: start coincident with a step pulse in IDLE, then
        // a start pulse while busy, on an N=3 full run.
        push_seq3();
        c0 = clr_cnt3; e0 = en_cnt3; w0 = we_cnt3; d0 = done_cnt3;
        r0 = rises;
        for (int i = 0; i < 40 && rises == r0; i++) @(posedge clock_in);
        @(negedge clock_in);
        start3 = 1'b1;
        @(negedge clock_in);
        start3 = 1'b0;
        r0 = rises;
        check("s5_idle_start_busy", busy3, 1);
        check("s5_no_early_clr", clr_cnt3, c0);
        for (int i = 0; i < 40 && clr_cnt3 == c0; i++) @(posedge clock_in);
        check("s5_first_clr_pulses", rises - r0, 1);
        repeat (30) @(negedge clock_in);
        start3 = 1'b1;
        @(negedge clock_in);
        start3 = 1'b0;
        wait_done(3, 800);
        check("s2_pulses", rises - r0, 45);
        @(posedge clock_in);
        check("s2_clr_cnt", clr_cnt3 - c0, 9);
        check("s2_en_cnt", en_cnt3 - e0, 27);
        check("s2_we_cnt", we_cnt3 - w0, 9);
        check("s2_done_cnt", done_cnt3 - d0, 1);
        @(negedge clock_in);
        check("s5_no_retrig", busy3, 0);
        repeat (10) @(negedge clock_in);
        check("s5_still_idle", busy3, 0);

        // Scenario 3: step_clk high through reset release.
        step_run   = 1'b0;
        step_force = 1'b1;
        @(negedge clock_in);
        reset = 1'b1;
        repeat (4) @(negedge clock_in);
        reset = 1'b0;
        repeat (4) @(negedge clock_in);
        push_seq3();
        pulse_start(3);
        repeat (12) @(negedge clock_in);
        check("s3_busy", busy3, 1);
        @(posedge clock_in);
        c0 = clr_cnt3;
        check("s3_no_strobe", clr_cnt3 + en_cnt3 + we_cnt3, c0 + en_cnt3 + we_cnt3);
        check("s3_state_clear", state_dbg3, 32'(ST_CLEAR));
        step_force = 1'b0;
        repeat (4) @(negedge clock_in);
        step_force = 1'b1;
        for (int i = 0; i < 12 && clr_cnt3 == c0; i++) @(posedge clock_in);
        check("s3_clr_after_edge", clr_cnt3, c0 + 1);
        @(negedge clock_in);
        reset = 1'b1;
        exp3_q.delete();
        repeat (3) @(negedge clock_in);
        reset    = 1'b0;
        step_run = 1'b1;

        // Scenario 4: reset after the 5th acc_en aborts the run.
        push_seq3();
        d0 = done_cnt3;
        align_fall();
        pulse_start(3);
        e0 = en_cnt3;
        for (int i = 0; i < 800 && en_cnt3 != e0 + 5; i++) @(posedge clock_in);
        check("s4_reached_en5", en_cnt3 - e0, 5);
        @(negedge clock_in);
        reset = 1'b1;
        @(negedge clock_in);
        check("s4_busy", busy3, 0);
        check("s4_strobes", {acc_clear3, acc_en3, c_we3, done3}, 0);
        check("s4_state", state_dbg3, 32'(ST_IDLE));
        exp3_q.delete();
        repeat (2) @(negedge clock_in);
        reset = 1'b0;
        push_seq3();
        align_fall();
        pulse_start(3);
        w0 = we_cnt3;
        for (int i = 0; i < 200 && we_cnt3 == w0; i++) @(posedge clock_in);
        check("s4_first_c", c_addr3, 0);
        check("s4_no_done_abort", done_cnt3, d0);
        wait_done(3, 800);
        @(posedge clock_in);
        check("s4_done_cnt", done_cnt3, d0 + 1);

        // Scenario 6: start held high gives back-to-back runs.
        push_seq3();
        push_seq3();
        d0 = done_cnt3;
        align_fall();
        @(negedge clock_in);
        start3 = 1'b1;
        wait_done(3, 800);
        check("s6_gap_idle", busy3, 0);
        check("s6_gap_state", state_dbg3, 32'(ST_IDLE));
        @(negedge clock_in);
        check("s6_retrigger", busy3, 1);
        start3 = 1'b0;
        wait_done(3, 800);
        @(negedge clock_in);
        check("s6_end_idle", busy3, 0);
        repeat (12) @(negedge clock_in);
        check("s6_stays_idle", busy3, 0);
        check("s6_done_cnt", done_cnt3 - d0, 2);

        @(posedge clock_in);
        check("q3_empty", exp3_q.size(), 0);
        check("q2_empty", exp2_q.size(), 0);
        check("dut2_done_total", done_cnt2, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
